// File: rtl/g15_pkg.sv
// Shared G-15 drum geometry constants and command-line select codes.
package g15_pkg;

    localparam int unsigned G15_WORD_BITS = 29;
    localparam int unsigned G15_WORDS     = 108;
    localparam int unsigned G15_LINE_BITS = G15_WORD_BITS * G15_WORDS;

    typedef enum logic [2:0] {
        CMD_M0  = 3'd0,
        CMD_M1  = 3'd1,
        CMD_M2  = 3'd2,
        CMD_M3  = 3'd3,
        CMD_M4  = 3'd4,
        CMD_M5  = 3'd5,
        CMD_M6  = 3'd6,
        CMD_M19 = 3'd7
    } cmd_sel_e;

endpackage

// File: rtl/mem_line_bank_drum_track.sv
// One recirculating drum track: a plain N-bit delay line with no reset, so
// contents survive rst_n exactly like the physical drum.
module drum_track #(
    parameter int unsigned N = 3131
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        sr_q <= {sr_q[N-2:0], d_i};
    end

    assign q_o = sr_q[N-1];

endmodule

// File: rtl/mem_line_bank.sv
// Parametrised bank of recirculating drum lines with word-boundary command
// select register, drum position counter and early-bus / command-line taps.
module mem_line_bank
    import g15_pkg::*;
#(
    parameter  int unsigned LINES      = 7,
    parameter  int unsigned WORD_BITS  = G15_WORD_BITS,
    parameter  int unsigned WORDS      = G15_WORDS,
    parameter  int unsigned EXT_LINES  = 2,
    parameter  int unsigned MARK_LINES = 2,
    parameter  int unsigned SEL_W      = 3,
    localparam int unsigned LINE_BITS  = WORDS * WORD_BITS,
    localparam int unsigned BP_W       = $clog2(LINE_BITS)
) (
    input  logic                  CLOCK,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  dest_valid,
    input  logic [SEL_W-1:0]      dest_line,
    input  logic                  wr_data,
    input  logic                  key_mark,
    input  logic [MARK_LINES-1:0] mark_data,
    input  logic                  src_en,
    input  logic [SEL_W-1:0]      src_line,
    input  logic [EXT_LINES-1:0]  ext_in,
    input  logic                  sel_load,
    input  logic [SEL_W-1:0]      sel_val,
    input  logic                  sel_set_all,
    input  logic                  sel_clear,
    output logic [SEL_W-1:0]      sel,
    output logic                  sel_pending,
    output logic                  mc,
    output logic                  eb,
    output logic [LINES-1:0]      line_out,
    output logic [BP_W-1:0]       bit_pos,
    output logic                  word_end
);

    localparam int unsigned WB_W      = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned SEL_CODES = 1 << SEL_W;

    logic [BP_W-1:0]  bit_pos_q, bit_pos_d;
    logic [WB_W-1:0]  wbit_q, wbit_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             sel_req;
    logic [SEL_W-1:0] req_val;
    logic             mc_raw, eb_raw;

    // Separate in-word counter avoids a modulo on bit_pos; both wrap together.
    assign word_end = (wbit_q == WB_W'(WORD_BITS - 1));

    always_comb begin
        bit_pos_d = (bit_pos_q == BP_W'(LINE_BITS - 1)) ? '0 : bit_pos_q + 1'b1;
        wbit_d    = word_end ? '0 : wbit_q + 1'b1;
    end

    always_comb begin
        sel_req = sel_clear | sel_set_all | sel_load;
        if (sel_clear) begin
            req_val = '0;
        end else if (sel_set_all) begin
            req_val = '1;
        end else begin
            req_val = sel_val;
        end

        sel_d      = sel_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (word_end && pend_q) begin
            sel_d = pend_val_q;
        end
        // A request in a word_end cycle stays pending for the next word end.
        if (sel_req) begin
            pend_d     = 1'b1;
            pend_val_d = req_val;
        end else if (word_end) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            bit_pos_q  <= '0;
            wbit_q     <= '0;
            sel_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
        end else begin
            bit_pos_q  <= bit_pos_d;
            wbit_q     <= wbit_d;
            sel_q      <= sel_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

    assign bit_pos     = bit_pos_q;
    assign sel         = sel_q;
    assign sel_pending = pend_q;

    always_comb begin
        eb_raw = 1'b0;
        mc_raw = 1'b0;
        for (int unsigned i = 0; i < LINES; i++) begin
            if (src_line == SEL_W'(i)) eb_raw = line_out[i];
            if (sel_q == SEL_W'(i))    mc_raw = line_out[i];
        end
        // External codes that do not fit in SEL_W bits are unreachable.
        for (int unsigned j = 0; j < EXT_LINES; j++) begin
            if ((LINES + j) < SEL_CODES && sel_q == SEL_W'(LINES + j)) mc_raw = ext_in[j];
        end
    end

    assign eb = rst_n & src_en & eb_raw;
    assign mc = rst_n & mc_raw;

    for (genvar d = 0; d < LINES; d++) begin : g_line
        logic line_d, line_q, drum_q, wr_hit;

        assign wr_hit = wr_en & dest_valid & (dest_line == SEL_W'(d));

        if (d < MARK_LINES) begin : g_mark
            assign line_d = key_mark ? mark_data[d] : (wr_hit ? wr_data : line_q);
        end else begin : g_plain
            assign line_d = (!key_mark && wr_hit) ? wr_data : line_q;
        end

        drum_track #(.N(LINE_BITS - 1)) u_track (
            .clk_i (CLOCK),
            .d_i   (line_d),
            .q_o   (drum_q)
        );

        always_ff @(posedge CLOCK) begin
            line_q <= drum_q;
        end

        assign line_out[d] = line_q;
    end

endmodule
